// File: rtl/complex_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : complex_result_packer
// Description : Collects scalar complex results from the conjugate dot-product
//               engine, packs NO_OF_UNITS of them per wide word and writes the
//               words to result memory through a ready/valid port. Two
//               ping-pong buffers absorb write stalls; a word that finds no
//               free buffer is dropped and flagged as overflow.
//               Optional build macro PACKER_CONJ_EN: conjugate each result
//               (saturating negate of the imaginary half) before packing.
// Revision    : 1.0 - initial release
// ============================================================================
module complex_result_packer #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NO_OF_UNITS   = 8,   // power of two, at least 2
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ELEMENT_WIDTH-1:0]             result,
  input  logic                                 finish,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic                                 wr_en,
  input  logic                                 wr_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow,
  output logic [31:0]                          elements_written
);

  localparam int c_half   = ELEMENT_WIDTH / 2;
  localparam int c_lane_w = $clog2(NO_OF_UNITS);
  localparam int c_cnt_w  = c_lane_w + 1;

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_collect = 2'd1;
  localparam logic [1:0] c_drain   = 2'd2;
  localparam logic [1:0] c_done    = 2'd3;

  logic [1:0]                           r_state;
  logic [31:0]                          r_total;
  logic [31:0]                          r_recv;
  logic [31:0]                          r_elements_written;
  logic [ADDR_WIDTH-1:0]                r_base;
  logic                                 r_overflow;

  // Two-entry ring of pack buffers: allocation and issue both walk the ring
  // in order, so the buffer at the issue pointer is always the oldest word.
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] r_data [2];
  logic [ADDR_WIDTH-1:0]                r_addr [2];
  logic [c_cnt_w-1:0]                   r_cnt  [2];
  logic [1:0]                           r_pend;
  logic [1:0]                           r_fill;
  logic                                 r_aptr;
  logic                                 r_iptr;
  logic                                 r_cur;
  logic                                 r_cur_ok;

  logic [c_lane_w-1:0]                  w_lane;
  logic                                 w_lane0;
  logic                                 w_last_elem;
  logic                                 w_word_end;
  logic                                 w_free_a;
  logic                                 w_sel;
  logic                                 w_ok;
  logic                                 w_accept;
  logic                                 w_xfer;
  logic [ADDR_WIDTH-1:0]                w_addr_new;
  logic [ELEMENT_WIDTH-1:0]             w_elem;

`ifdef PACKER_CONJ_EN
  logic [c_half-1:0] w_imag;
  logic [c_half-1:0] w_imag_conj;
  assign w_imag      = result[c_half-1:0];
  // Negating the most negative value would wrap, so it saturates instead.
  assign w_imag_conj = (w_imag == {1'b1, {(c_half-1){1'b0}}}) ?
                       {1'b0, {(c_half-1){1'b1}}} : -w_imag;
  assign w_elem      = {result[ELEMENT_WIDTH-1:c_half], w_imag_conj};
`else
  assign w_elem      = result;
`endif

  assign w_lane      = r_recv[c_lane_w-1:0];
  assign w_lane0     = (w_lane == '0);
  assign w_last_elem = ((r_recv + 32'd1) == r_total);
  assign w_word_end  = (w_lane == c_lane_w'(NO_OF_UNITS - 1)) || w_last_elem;
  assign w_free_a    = !r_pend[r_aptr] && !r_fill[r_aptr];
  assign w_sel       = w_lane0 ? r_aptr : r_cur;
  assign w_ok        = w_lane0 ? w_free_a : r_cur_ok;
  assign w_accept    = (r_state == c_collect) && finish;
  assign w_xfer      = r_pend[r_iptr] && wr_ready;
  assign w_addr_new  = r_base + r_recv[ADDR_WIDTH+c_lane_w-1:c_lane_w];

  assign wr_en            = r_pend[r_iptr];
  assign wr_data          = r_data[r_iptr];
  assign wr_addr          = r_addr[r_iptr];
  assign busy             = (r_state == c_collect) || (r_state == c_drain);
  assign done             = (r_state == c_done);
  assign overflow         = r_overflow;
  assign elements_written = r_elements_written;

  // Buffer datapath: zero-fill on allocation, then drop each result into its lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        r_data[b] <= '0;
        r_addr[b] <= '0;
        r_cnt[b]  <= '0;
      end
    end else if (w_accept && w_ok) begin
      for (int k = 0; k < NO_OF_UNITS; k++) begin
        if (int'(w_lane) == k) begin
          r_data[w_sel][k*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= w_elem;
        end else if (w_lane0) begin
          r_data[w_sel][k*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= '0;
        end
      end
      if (w_lane0) begin
        r_addr[w_sel] <= w_addr_new;
      end
      r_cnt[w_sel] <= {1'b0, w_lane} + c_cnt_w'(1);
    end
  end

  // Control: state machine, buffer ownership, write-port handshake, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= c_idle;
      r_total            <= '0;
      r_recv             <= '0;
      r_elements_written <= '0;
      r_base             <= '0;
      r_overflow         <= 1'b0;
      r_pend             <= '0;
      r_fill             <= '0;
      r_aptr             <= 1'b0;
      r_iptr             <= 1'b0;
      r_cur              <= 1'b0;
      r_cur_ok           <= 1'b0;
    end else begin
      // Freeing the issued buffer; it is only seen as free from next cycle.
      if (w_xfer) begin
        r_pend[r_iptr]     <= 1'b0;
        r_iptr             <= ~r_iptr;
        r_elements_written <= r_elements_written + 32'(r_cnt[r_iptr]);
      end

      case (r_state)
        c_idle: begin
          if (start) begin
            r_total            <= total;
            r_base             <= base_addr;
            r_recv             <= '0;
            r_elements_written <= '0;
            r_overflow         <= 1'b0;
            r_state            <= (total == 32'd0) ? c_done : c_collect;
          end
        end
        c_collect: begin
          if (finish) begin
            r_recv <= r_recv + 32'd1;
            if (w_lane0) begin
              if (w_free_a) begin
                r_fill[r_aptr] <= 1'b1;
                r_cur          <= r_aptr;
                r_cur_ok       <= 1'b1;
                r_aptr         <= ~r_aptr;
              end else begin
                // Whole word is dropped; its lanes still advance recv.
                r_overflow <= 1'b1;
                r_cur_ok   <= 1'b0;
              end
            end
            if (w_ok && w_word_end) begin
              r_fill[w_sel] <= 1'b0;
              r_pend[w_sel] <= 1'b1;
            end
            if (w_last_elem) begin
              r_state <= c_drain;
            end
          end
        end
        c_drain: begin
          if (r_pend == 2'b00) begin
            r_state <= c_done;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_complex_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_complex_result_packer
// Description : Scoreboard bench for complex_result_packer. Expected packed
//               words are queued when results are driven and compared when
//               the write port transfers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complex_result_packer;

  localparam int EW = 64;
  localparam int NU = 8;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       total = '0;
  logic [AW-1:0]     base_addr = '0;
  logic [EW-1:0]     result = '0;
  logic              finish = 1'b0;
  logic              wr_ready = 1'b1;
  logic [EW*NU-1:0]  wr_data;
  logic [AW-1:0]     wr_addr;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [31:0]       elements_written;

  complex_result_packer #(
    .ELEMENT_WIDTH (EW),
    .NO_OF_UNITS   (NU),
    .ADDR_WIDTH    (AW)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .total            (total),
    .base_addr        (base_addr),
    .result           (result),
    .finish           (finish),
    .wr_data          (wr_data),
    .wr_addr          (wr_addr),
    .wr_en            (wr_en),
    .wr_ready         (wr_ready),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .elements_written (elements_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_wr     = 0;
  int n_wren   = 0;
  int exp_ew   = 0;

  logic [EW*NU-1:0] sb_data[$];
  logic [AW-1:0]    sb_addr[$];
  logic [EW-1:0]    stim[$];

  task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference element transform.
  function automatic logic [EW-1:0] model_elem(input logic [EW-1:0] r);
`ifdef PACKER_CONJ_EN
    logic [31:0] im;
    im = r[31:0];
    if (im == 32'h8000_0000) return {r[63:32], 32'h7FFF_FFFF};
    return {r[63:32], 32'd0 - im};
`else
    return r;
`endif
  endfunction

  // Write-port monitor: pop and compare every accepted word.
  always @(negedge clk) begin
    if (reset) begin
      if (done) n_done++;
      if (wr_en) n_wren++;
      if (wr_en && wr_ready) begin
        n_wr++;
        if (sb_data.size() == 0) begin
          check_value("sb_pending", sb_data.size(), 1);
        end else begin
          check_value("wr_data", wr_data, sb_data.pop_front());
          check_value("wr_addr", wr_addr, sb_addr.pop_front());
        end
      end
    end
  end

  // Queue the words the first keep_words words of stim should produce.
  task automatic push_expected(input int t, input logic [AW-1:0] base, input int keep_words);
    int nwords;
    logic [EW*NU-1:0] word;
    nwords = (t + NU - 1) / NU;
    exp_ew = 0;
    for (int w = 0; w < nwords && w < keep_words; w++) begin
      word = '0;
      for (int l = 0; l < NU; l++) begin
        if (w*NU + l < t) word[l*EW +: EW] = model_elem(stim[w*NU + l]);
      end
      sb_data.push_back(word);
      sb_addr.push_back(base + AW'(w));
      exp_ew += ((t - w*NU) < NU) ? (t - w*NU) : NU;
    end
  endtask

  task automatic apply_start(input int t, input logic [AW-1:0] base);
    @(posedge clk); #1;
    n_done    = 0;
    total     = t;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_results(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      finish = 1'b1;
      result = stim[i];
      @(posedge clk); #1;
    end
    finish = 1'b0;
  endtask

  task automatic finish_case(input logic exp_ovf);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check_value("done_seen", got, 1);
    repeat (3) @(negedge clk);
    check_value("done_pulses", n_done, 1);
    check_value("sb_empty", sb_data.size(), 0);
    check_value("elements_written", elements_written, exp_ew);
    check_value("overflow", overflow, exp_ovf);
    check_value("busy_idle", busy, 0);
  endtask

  initial begin
    int wr0;
    // Reset state
    #1;
    check_value("rst_wr_en", wr_en, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_overflow", overflow, 0);
    check_value("rst_ew", elements_written, 0);
    check_value("rst_wr_addr", wr_addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 16 results, two full words
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(EW'(i));
    push_expected(16, 16'h0010, 99);
    apply_start(16, 16'h0010);
    check_value("busy_after_start", busy, 1);
    send_results(0, 16);
    finish_case(1'b0);

    // 10 results, partial last word
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back({$urandom(), $urandom()});
    push_expected(10, 16'h0000, 99);
    apply_start(10, 16'h0000);
    send_results(0, 10);
    finish_case(1'b0);

    // Stalled write port: third word dropped
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back({$urandom(), $urandom()});
    push_expected(24, 16'hFFFF, 2);
    wr_ready = 1'b0;
    wr0 = n_wr;
    apply_start(24, 16'hFFFF);
    send_results(0, 24);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_value("stall_wr_en", wr_en, 1);
    check_value("stall_wr_addr", wr_addr, 16'hFFFF);
    check_value("stall_wr_data", wr_data, sb_data[0]);
    check_value("stall_overflow", overflow, 1);
    check_value("stall_busy", busy, 1);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    finish_case(1'b1);
    check_value("stall_write_count", n_wr - wr0, 2);

    // total == 0
    wr0 = n_wren;
    exp_ew = 0;
    apply_start(0, 16'h0055);
    check_value("zero_busy", busy, 0);
    finish_case(1'b0);
    check_value("zero_no_wr_en", n_wren - wr0, 0);

    // Conjugate-sensitive values
    stim.delete();
    stim.push_back({32'd3, 32'hFFFF_FFFE});
    stim.push_back({32'd5, 32'h8000_0000});
    push_expected(2, 16'h0030, 99);
    apply_start(2, 16'h0030);
    send_results(0, 2);
    finish_case(1'b0);

    // Asynchronous reset mid-word with a write pending
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back({$urandom(), $urandom()});
    push_expected(24, 16'h0040, 2);
    wr_ready = 1'b0;
    apply_start(24, 16'h0040);
    send_results(0, 17);
    @(negedge clk);
    check_value("pre_rst_wr_en", wr_en, 1);
    check_value("pre_rst_overflow", overflow, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_value("async_rst_wr_en", wr_en, 0);
    check_value("async_rst_busy", busy, 0);
    check_value("async_rst_overflow", overflow, 0);
    sb_data.delete();
    sb_addr.delete();
    @(posedge clk); #1;
    reset    = 1'b1;
    wr_ready = 1'b1;

    // Fresh run after reset
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back({$urandom(), $urandom()});
    push_expected(8, 16'h0020, 99);
    wr0 = n_wr;
    apply_start(8, 16'h0020);
    send_results(0, 8);
    finish_case(1'b0);
    check_value("post_rst_write_count", n_wr - wr0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
